// File: rtl/sa_pkg.sv
// Shared types for the systolic-array result drain: drain FSM states and FP32 width.
package sa_pkg;
  localparam int FP32_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } drain_state_e;
endpackage

// File: rtl/sa_result_buf.sv
// Capture buffer for one full M x N FP32 tile, written whole, read one row at a time.
module sa_result_buf
  import sa_pkg::*;
#(
  parameter int M  = 8,
  parameter int N  = 8,
  parameter int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [M*N*FP32_W-1:0]   wdata_i,
  input  logic [IW-1:0]           rd_idx_i,
  output logic [N*FP32_W-1:0]     rd_data_o
);
  localparam int RW = N * FP32_W;

  logic [M-1:0][RW-1:0] mem_q;

  // Storage only changes on capture; no reset needed since contents are never read stale.
  always_ff @(posedge clk) begin
    if (we_i) mem_q <= wdata_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/sa_tile_result_drain.sv
// Waits for a full tile of SA results, captures it, then streams it out one row per beat.
module sa_tile_result_drain
  import sa_pkg::*;
#(
  parameter int M       = 8,
  parameter int N       = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                tile_done,
  input  logic [M*N*FP32_W-1:0]               c_out_flat,
  input  logic [M*N-1:0]                      c_valid_flat,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N*FP32_W-1:0]                 out_row_flat,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row_idx,
  output logic                                out_last,
  output logic                                drain_busy,
  output logic                                drain_done,
  input  logic                                err_clr,
  output logic                                err_timeout,
  output logic                                err_overrun
);
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = N * FP32_W;

  drain_state_e  state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [IW-1:0] row_q, row_d;
  logic [RW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          err_to_q, err_to_d, err_ov_q, err_ov_d;
  logic          all_valid, capture, tmo_set, ovr_set, xfer;
  logic [RW-1:0] buf_rd;

  assign all_valid = &c_valid_flat;
  assign capture   = (state_q == S_WAIT) && all_valid;
  assign xfer      = (state_q == S_STREAM) && out_ready;
  assign ovr_set   = tile_done && (state_q != S_IDLE);

  // Read port looks one row ahead so the next beat is ready to register on transfer.
  sa_result_buf #(.M(M), .N(N), .IW(IW)) u_buf (
    .clk      (clk),
    .we_i     (capture),
    .wdata_i  (c_out_flat),
    .rd_idx_i (row_q + 1'b1),
    .rd_data_o(buf_rd)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    row_d   = row_q;
    data_d  = data_q;
    last_d  = last_q;
    tmo_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tile_done) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        // All-valid wins over the timeout on the final count.
        if (all_valid) begin
          state_d = S_STREAM;
          row_d   = '0;
          data_d  = c_out_flat[RW-1:0];
          last_d  = (M == 1);
        end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            row_d  = row_q + 1'b1;
            data_d = buf_rd;
            last_d = ((32'(row_q) + 32'd1) == 32'(M - 1));
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Error events take priority over a same-cycle clear.
  assign err_to_d = tmo_set | (err_to_q & ~err_clr);
  assign err_ov_d = ovr_set | (err_ov_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      row_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      row_q    <= row_d;
      data_q   <= data_d;
      last_q   <= last_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
    end
  end

  assign out_valid    = (state_q == S_STREAM);
  assign out_row_flat = data_q;
  assign out_row_idx  = row_q;
  assign out_last     = last_q;
  assign drain_busy   = (state_q != S_IDLE);
  assign drain_done   = (state_q == S_DONE);
  assign err_timeout  = err_to_q;
  assign err_overrun  = err_ov_q;
endmodule

// File: tb/tb_sa_tile_result_drain.sv
// Directed + randomized bench for sa_tile_result_drain (M=N=2, TIMEOUT=16) with a tile-snapshot model.
module tb_sa_tile_result_drain;
  localparam int M  = 2;
  localparam int N  = 2;
  localparam int TO = 16;
  localparam int RW = N * 32;
  localparam int TW = M * N * 32;

  logic          clk = 1'b0;
  logic          rst, tile_done, out_ready, err_clr;
  logic [TW-1:0] c_out;
  logic [M*N-1:0] c_valid;
  logic          out_valid, out_last, drain_busy, drain_done, err_timeout, err_overrun;
  logic [RW-1:0] out_row_flat;
  logic [0:0]    out_row_idx;

  int checks = 0;
  int failures = 0;

  sa_tile_result_drain #(.M(M), .N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .tile_done(tile_done),
    .c_out_flat(c_out), .c_valid_flat(c_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row_flat(out_row_flat), .out_row_idx(out_row_idx), .out_last(out_last),
    .drain_busy(drain_busy), .drain_done(drain_done),
    .err_clr(err_clr), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int w = 0; w < M * N; w++) t[w*32 +: 32] = $urandom;
    return t;
  endfunction

  // Model: the tile is the snapshot of c_out on the first WAIT cycle with all valids high;
  // beat r carries row r of that snapshot, regardless of later c_out activity.
  task automatic do_tile(input logic [TW-1:0] data, input int vdelay, input int pct,
                         input int hold, input bit ovr);
    int cap, r, cyc, h;
    logic [TW-1:0] snap;
    h = hold;
    c_out = data;
    c_valid = (vdelay == 0) ? '1 : '0;
    tile_done = 1'b1;
    step();
    tile_done = 1'b0;
    cap = (vdelay < 1) ? 1 : vdelay;
    for (int k = 1; k < cap; k++) begin
      chk("wait_no_valid", out_valid, 1'b0);
      chk("wait_busy", drain_busy, 1'b1);
      step();
    end
    c_valid = '1;
    snap = c_out;
    step();
    r = 0;
    cyc = 0;
    while (r < M && cyc < 200) begin
      chk("str_valid", out_valid, 1'b1);
      chk("str_idx", out_row_idx, r);
      chk("str_data", out_row_flat, snap[r*RW +: RW]);
      chk("str_last", out_last, (r == M - 1));
      chk("str_no_done", drain_done, 1'b0);
      out_ready = (h > 0) ? 1'b0 : ($urandom_range(0, 99) < pct);
      if (h > 0) h--;
      if (ovr && cyc == 0) begin
        tile_done = 1'b1;
        err_clr = 1'b1;
      end
      c_out = rand_tile();
      c_valid = 4'($urandom);
      step();
      tile_done = 1'b0;
      err_clr = 1'b0;
      if (out_ready) r++;
      cyc++;
    end
    out_ready = 1'b0;
    chk("str_budget", (cyc < 200), 1'b1);
    chk("done_pulse", drain_done, 1'b1);
    chk("done_no_valid", out_valid, 1'b0);
    if (ovr) chk("overrun_set", err_overrun, 1'b1);
    step();
    chk("done_once", drain_done, 1'b0);
    chk("idle_busy", drain_busy, 1'b0);
  endtask

  initial begin
    logic [TW-1:0] fixed;
    rst = 1'b1; tile_done = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    c_out = '0; c_valid = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_busy", drain_busy, 1'b0);
    chk("rst_done", drain_done, 1'b0);
    chk("rst_idx", out_row_idx, 1'b0);
    chk("rst_data", out_row_flat, '0);
    chk("rst_errs", {err_timeout, err_overrun}, 2'b00);

    // 1.0, 2.0, 3.0, 4.0 at elements (0,0),(0,1),(1,0),(1,1); full-rate drain.
    fixed = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    do_tile(fixed, 0, 100, 0, 1'b0);

    // Valids arrive 5 cycles after tile_done.
    do_tile(rand_tile(), 5, 100, 0, 1'b0);
    chk("late_valid_no_tmo", err_timeout, 1'b0);

    // Backpressure on row 0 for 3 cycles while c_out churns.
    do_tile(rand_tile(), 0, 100, 3, 1'b0);

    // Second tile_done during STREAM together with err_clr: flag must still set.
    do_tile(rand_tile(), 0, 100, 0, 1'b1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("overrun_clr", err_overrun, 1'b0);

    // Timeout: 16 WAIT cycles (counter 0..15) are decided in cycle T+16, flag visible T+17.
    c_valid = 4'b0111;
    tile_done = 1'b1; step(); tile_done = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      chk("tmo_not_yet", err_timeout, 1'b0);
      chk("tmo_no_valid", out_valid, 1'b0);
      step();
    end
    chk("tmo_set", err_timeout, 1'b1);
    chk("tmo_idle", drain_busy, 1'b0);
    chk("tmo_no_done", drain_done, 1'b0);
    step();
    chk("tmo_sticky", err_timeout, 1'b1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("tmo_clr", err_timeout, 1'b0);

    // Randomized tiles: valid delays, throttled ready.
    for (int t = 0; t < 20; t++)
      do_tile(rand_tile(), $urandom_range(0, 10), $urandom_range(20, 100), 0, 1'b0);
    chk("rand_no_errs", {err_timeout, err_overrun}, 2'b00);

    // Reset mid-STREAM aborts without drain_done.
    c_out = rand_tile(); c_valid = '1;
    tile_done = 1'b1; step(); tile_done = 1'b0;
    tile_done = 1'b1; step(); tile_done = 1'b0;
    chk("pre_rst_stream", out_valid, 1'b1);
    chk("pre_rst_ovr", err_overrun, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", drain_busy, 1'b0);
    chk("mid_rst_done", drain_done, 1'b0);
    chk("mid_rst_data", out_row_flat, '0);
    chk("mid_rst_idx_last", {out_row_idx, out_last}, 2'b00);
    chk("mid_rst_errs", {err_timeout, err_overrun}, 2'b00);
    c_valid = '0;
    step();
    chk("post_rst_done", drain_done, 1'b0);
    chk("post_rst_idle", drain_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
